// File: rtl/block_decoder_pkg.sv
// rtl/block_decoder_pkg.sv - cipher constants, state encoding and S-box/key-schedule helpers
package block_decoder_pkg;

  localparam int BLOCK_LEN = 64;
  localparam int KEY_LEN   = 80;
  localparam int NROUNDS   = 25;
  localparam int RC_W      = 5;

  // Nibble n of each table holds the substitution of n.
  localparam logic [63:0] SBOX_TBL     = 64'h6358_F02D_AC97_1B4E;
  localparam logic [63:0] INV_SBOX_TBL = 64'hB086_275C_4FD1_E93A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEXP,
    ST_WHITEN,
    ST_ROUND
  } dec_state_t;

  function automatic logic [3:0] sbox(input logic [3:0] n);
    return SBOX_TBL[4*n +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] n);
    return INV_SBOX_TBL[4*n +: 4];
  endfunction

  function automatic int lane_rot(input int lane);
    case (lane)
      0:       return 1;
      1:       return 4;
      2:       return 7;
      default: return 9;
    endcase
  endfunction

  function automatic logic [15:0] rotr16(input logic [15:0] v, input int n);
    return (v >> n) | (v << (16 - n));
  endfunction

  // Forward key step: rotate left 13, inject round counter, substitute low nibble.
  function automatic logic [KEY_LEN-1:0] key_gen(input logic [KEY_LEN-1:0] k,
                                                 input logic [RC_W-1:0]    rc);
    logic [KEY_LEN-1:0] w;
    w         = {k[66:0], k[79:67]};
    w[63:59]  = w[63:59] ^ rc;
    w[3:0]    = sbox(w[3:0]);
    return w;
  endfunction

endpackage

// File: rtl/block_decoder_if.sv
// rtl/block_decoder_if.sv - start/done request interface between a requester and the decoder
interface block_decoder_if;
  import block_decoder_pkg::*;

  logic                 start;
  logic [BLOCK_LEN-1:0] c_text;
  logic [KEY_LEN-1:0]   m_key;
  logic                 busy;
  logic                 done;
  logic [BLOCK_LEN-1:0] p_text;

  modport master (
    output start, c_text, m_key,
    input  busy, done, p_text
  );

  modport slave (
    input  start, c_text, m_key,
    output busy, done, p_text
  );

endinterface

// File: rtl/block_decoder_round_dec.sv
// rtl/block_decoder_round_dec.sv - combinational inverse round and inverse key step
module block_decoder_round_dec
  import block_decoder_pkg::*;
(
  input  logic [KEY_LEN-1:0]   key,
  input  logic [RC_W-1:0]      rc,
  input  logic [BLOCK_LEN-1:0] s,
  output logic [BLOCK_LEN-1:0] s_next,
  output logic [KEY_LEN-1:0]   key_prev
);

  logic [3:0][15:0]     x;
  logic [3:0][15:0]     w;
  logic [3:0][15:0]     unrot;
  logic [BLOCK_LEN-1:0] unswap;
  logic [BLOCK_LEN-1:0] unsub;
  logic [KEY_LEN-1:0]   kw;

  assign x = s;

  // Undo the XOR mix; lanes 3 and 0 first since 2 and 1 depend on them.
  assign w[3] = x[3] ^ x[2];
  assign w[0] = x[0] ^ x[1];
  assign w[2] = x[2] ^ w[0];
  assign w[1] = x[1] ^ w[3];

  always_comb begin
    unrot  = '0;
    unswap = '0;
    for (int i = 0; i < 4; i++) begin
      unrot[i]             = rotr16(w[i], lane_rot(i));
      unswap[16*i +: 16]   = {unrot[i][7:0], unrot[i][15:8]};
    end
  end

  always_comb begin
    unsub = '0;
    for (int i = 0; i < 16; i++) begin
      unsub[4*i +: 4] = inv_sbox(unswap[4*i +: 4]);
    end
  end

  assign s_next = unsub ^ key[BLOCK_LEN-1:0];

  always_comb begin
    kw        = key;
    kw[3:0]   = inv_sbox(key[3:0]);
    kw[63:59] = key[63:59] ^ rc;
  end

  assign key_prev = {kw[12:0], kw[79:13]};

endmodule

// File: rtl/block_decoder.sv
// rtl/block_decoder.sv - iterative 25-round decryptor, one inverse round per clock
module block_decoder
  import block_decoder_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  block_decoder_if.slave io
);

  dec_state_t           state_q, state_d;
  logic [RC_W-1:0]      rc_q, rc_d, ikg_rc;
  logic [KEY_LEN-1:0]   key_q, key_d, key_prev;
  logic [BLOCK_LEN-1:0] s_q, s_d, s_next;
  logic [BLOCK_LEN-1:0] p_q, p_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // WHITEN steps K25 back to K24; each ROUND steps Krc back to Krc-1.
  assign ikg_rc = (state_q == ST_WHITEN) ? RC_W'(NROUNDS - 1) : rc_q - RC_W'(1);

  block_decoder_round_dec u_round_dec (
    .key      (key_q),
    .rc       (ikg_rc),
    .s        (s_q),
    .s_next   (s_next),
    .key_prev (key_prev)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rc_q    <= '0;
      key_q   <= '0;
      s_q     <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      key_q   <= key_d;
      s_q     <= s_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    key_d   = key_q;
    s_d     = s_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = done_q;
    unique case (state_q)
      ST_IDLE: begin
        done_d = 1'b0;
        if (io.start) begin
          s_d     = io.c_text;
          key_d   = io.m_key;
          rc_d    = '0;
          busy_d  = 1'b1;
          state_d = ST_KEXP;
        end
      end
      ST_KEXP: begin
        key_d = key_gen(key_q, rc_q);
        rc_d  = rc_q + RC_W'(1);
        if (rc_q == RC_W'(NROUNDS - 1)) begin
          state_d = ST_WHITEN;
        end
      end
      ST_WHITEN: begin
        s_d     = s_q ^ key_q[BLOCK_LEN-1:0];
        key_d   = key_prev;
        rc_d    = RC_W'(NROUNDS - 1);
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        s_d = s_next;
        if (rc_q != '0) begin
          key_d = key_prev;
          rc_d  = rc_q - RC_W'(1);
        end else begin
          p_d     = s_next;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign io.busy   = busy_q;
  assign io.done   = done_q;
  assign io.p_text = p_q;

endmodule
